// File: rtl/memory_load_unit_if.sv
// Load-unit bus bundle: core request handshake, memory read port and
// response handshake.
//   slave  : the load unit (drives req_ready, mem_address, resp_*)
//   master : the core/memory side (drives req_*, mem_read_data, resp_ready)
interface memory_load_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_address;
  logic [2:0]  req_funct3;
  logic [31:0] mem_address;
  logic [31:0] mem_read_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        resp_error;

  modport slave (
    input  req_valid, req_address, req_funct3, mem_read_data, resp_ready,
    output req_ready, mem_address, resp_valid, resp_data, resp_error
  );

  modport master (
    output req_valid, req_address, req_funct3, mem_read_data, resp_ready,
    input  req_ready, mem_address, resp_valid, resp_data, resp_error
  );
endinterface

// File: rtl/memory_load_unit.sv
// memory_load_unit: read-side companion to the byte-addressable data memory.
// Accepts LB/LH/LW/LBU/LHU requests, drives the memory address, samples the
// read data MEM_LATENCY edges after acceptance, then extracts and extends the
// addressed field and returns it over a valid/ready response.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : request / memory read / response signals (slave side)
module memory_load_unit #(
  parameter int MEM_LATENCY = 1  // legal range 1..7
) (
  input  logic                       clk,
  input  logic                       reset,
  memory_load_unit_if.slave          bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  state_t     state;
  logic [2:0] cnt;
  logic [2:0] funct3_q;

  function automatic logic legal_f3(input logic [2:0] f);
    return (f == F3_LB) || (f == F3_LH) || (f == F3_LW) ||
           (f == F3_LBU) || (f == F3_LHU);
  endfunction

  // The addressed byte sits in the top lane of the read word, so every
  // field is taken from the MSB end.
  function automatic logic [31:0] extract(input logic [2:0] f,
                                          input logic [31:0] d);
    logic [31:0] r;
    case (f)
      F3_LB:   r = {{24{d[31]}}, d[31:24]};
      F3_LBU:  r = {24'b0, d[31:24]};
      F3_LH:   r = {{16{d[31]}}, d[31:16]};
      F3_LHU:  r = {16'b0, d[31:16]};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      funct3_q        <= '0;
      bus.req_ready   <= 1'b1;
      bus.mem_address <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_data   <= '0;
      bus.resp_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            funct3_q        <= bus.req_funct3;
            bus.mem_address <= bus.req_address;
            bus.req_ready   <= 1'b0;
            if (legal_f3(bus.req_funct3)) begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end else begin
              // Illegal code skips the memory wait entirely.
              bus.resp_error <= 1'b1;
              bus.resp_data  <= '0;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            bus.resp_data  <= extract(funct3_q, bus.mem_read_data);
            bus.resp_error <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          // req_ready comes back only after the handshake edge, so a new
          // request can never overlap the response it follows.
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            bus.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          bus.req_ready  <= 1'b1;
          bus.resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_load_unit.sv
module tb_memory_load_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  memory_load_unit_if bus1 ();
  memory_load_unit_if bus3 ();

  memory_load_unit #(.MEM_LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
  memory_load_unit #(.MEM_LATENCY(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  // Byte memory shared by both units, big-byte-first read word.
  logic [7:0] mem [0:63];
  logic [5:0] a1_0, a1_1, a1_2, a1_3, a3_0, a3_1, a3_2, a3_3;
  assign a1_0 = bus1.mem_address[5:0];
  assign a1_1 = a1_0 + 6'd1;
  assign a1_2 = a1_0 + 6'd2;
  assign a1_3 = a1_0 + 6'd3;
  assign a3_0 = bus3.mem_address[5:0];
  assign a3_1 = a3_0 + 6'd1;
  assign a3_2 = a3_0 + 6'd2;
  assign a3_3 = a3_0 + 6'd3;
  assign bus1.mem_read_data = {mem[a1_0], mem[a1_1], mem[a1_2], mem[a1_3]};
  assign bus3.mem_read_data = {mem[a3_0], mem[a3_1], mem[a3_2], mem[a3_3]};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rv(input bit sel);
    return 32'(sel ? bus3.resp_valid : bus1.resp_valid);
  endfunction
  function automatic logic [31:0] rdy(input bit sel);
    return 32'(sel ? bus3.req_ready : bus1.req_ready);
  endfunction
  function automatic logic [31:0] rdat(input bit sel);
    return sel ? bus3.resp_data : bus1.resp_data;
  endfunction
  function automatic logic [31:0] rerr(input bit sel);
    return 32'(sel ? bus3.resp_error : bus1.resp_error);
  endfunction
  function automatic logic [31:0] maddr(input bit sel);
    return sel ? bus3.mem_address : bus1.mem_address;
  endfunction

  task automatic set_req(input bit sel, input logic v, input logic [31:0] a, input logic [2:0] f);
    if (sel) begin
      bus3.req_valid = v; bus3.req_address = a; bus3.req_funct3 = f;
    end else begin
      bus1.req_valid = v; bus1.req_address = a; bus1.req_funct3 = f;
    end
  endtask

  // One load with resp_ready held high; checks address, latency, result and
  // the return to idle after the handshake.
  task automatic load(input bit sel, input string tag, input logic [31:0] a,
                      input logic [2:0] f, input logic [31:0] exp_d,
                      input logic exp_e, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, ".rdy_idle"}, rdy(sel), 32'd1);
    set_req(sel, 1'b1, a, f);
    @(posedge clk); #1;
    set_req(sel, 1'b0, 32'hDEAD_BEEF, 3'b111);
    chk({tag, ".maddr"}, maddr(sel), a);
    lat = 0;
    while (rv(sel) == 32'd0 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".data"}, rdat(sel), exp_d);
    chk({tag, ".err"}, rerr(sel), 32'(exp_e));
    chk({tag, ".rdy_busy"}, rdy(sel), 32'd0);
    @(posedge clk); #1;
    chk({tag, ".rv_clr"}, rv(sel), 32'd0);
    chk({tag, ".rdy_back"}, rdy(sel), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[20] = 8'h12; mem[21] = 8'h34; mem[22] = 8'h56; mem[23] = 8'h78;
    mem[40] = 8'h80; mem[41] = 8'hF1; mem[42] = 8'h7F; mem[43] = 8'h00;
    set_req(1'b0, 1'b0, 32'd0, 3'd0);
    set_req(1'b1, 1'b0, 32'd0, 3'd0);
    bus1.resp_ready = 1'b1;
    bus3.resp_ready = 1'b1;

    #12;
    chk("rst.rdy", rdy(0), 32'd1);
    chk("rst.rv", rv(0), 32'd0);
    chk("rst.maddr", maddr(0), 32'd0);
    chk("rst.data", rdat(0), 32'd0);
    chk("rst.err", rerr(0), 32'd0);
    @(negedge clk); reset = 1'b0;

    load(0, "lw20",  32'd20, 3'b010, 32'h1234_5678, 1'b0, 1);
    load(0, "lb40",  32'd40, 3'b000, 32'hFFFF_FF80, 1'b0, 1);
    load(0, "lbu40", 32'd40, 3'b100, 32'h0000_0080, 1'b0, 1);
    load(0, "lh40",  32'd40, 3'b001, 32'hFFFF_80F1, 1'b0, 1);
    load(0, "lhu40", 32'd40, 3'b101, 32'h0000_80F1, 1'b0, 1);
    load(0, "lb42",  32'd42, 3'b000, 32'h0000_007F, 1'b0, 1);
    load(0, "lh41",  32'd41, 3'b001, 32'hFFFF_F17F, 1'b0, 1);

    // Backpressure with request inputs disturbed during the stall.
    @(negedge clk);
    bus1.resp_ready = 1'b0;
    set_req(0, 1'b1, 32'd20, 3'b010);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd40, 3'b000);
    lat = 0;
    while (rv(0) == 32'd0 && lat < 20) begin
      @(posedge clk); #1; lat++;
      bus1.req_address = 32'd41 + 32'(lat); bus1.req_funct3 = 3'b001;
    end
    chk("bp.lat", 32'(lat), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      bus1.req_address = 32'd44 + 32'(k);
      chk("bp.rv", rv(0), 32'd1);
      chk("bp.data", rdat(0), 32'h1234_5678);
      chk("bp.rdy", rdy(0), 32'd0);
    end
    bus1.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp.rv_clr", rv(0), 32'd0);
    chk("bp.rdy_back", rdy(0), 32'd1);
    chk("bp.maddr_hold", maddr(0), 32'd20);

    load(0, "ill011", 32'd20, 3'b011, 32'h0000_0000, 1'b1, 0);
    load(0, "lbu21",  32'd21, 3'b100, 32'h0000_0034, 1'b0, 1);

    load(1, "l3.lw20", 32'd20, 3'b010, 32'h1234_5678, 1'b0, 3);

    // Reset between edges while the latency-3 unit is waiting.
    @(negedge clk);
    set_req(1, 1'b1, 32'd20, 3'b010);
    @(posedge clk); #1;
    set_req(1, 1'b0, 32'd0, 3'b010);
    chk("mid.maddr", maddr(1), 32'd20);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid.rv", rv(1), 32'd0);
    chk("mid.rdy", rdy(1), 32'd1);
    chk("mid.maddr_rst", maddr(1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (rv(1) != 32'd0) seen++;
    end
    chk("mid.no_resp", 32'(seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
